// File: rtl/ksa_multiword_seq.sv
// Multi-word add/subtract sequencer: streams byte slices LSB-first through an
// external 8-bit carry-less Kogge-Stone adder and chains the carry itself.
module ksa_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   op_a,
  input  logic [8*WORDS-1:0]   op_b,
  input  logic                 op_sub,
  output logic [7:0]           ksa_a,
  output logic [7:0]           ksa_b,
  input  logic [7:0]           ksa_sum,
  input  logic                 ksa_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   result,
  output logic                 carryout,
  output logic                 overflow
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       result_q, result_d;
  logic               carryout_q, carryout_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [7:0]         ksa_a_q, ksa_a_d;
  logic [7:0]         ksa_b_q, ksa_b_d;

  logic               accept_s;
  logic               last_s;
  logic [IDX_W-1:0]   idx_inc_s;
  logic [7:0]         byte_s;
  logic               carry_next_s;

  assign accept_s  = in_valid & in_ready_q;
  assign last_s    = (idx_q == IDX_W'(WORDS - 1));
  assign idx_inc_s = idx_q + IDX_W'(1);
  assign byte_s    = ksa_sum + {7'd0, carry_q};
  // Carry-in of 1 can only ripple out of a byte whose KSA sum is all ones;
  // a KSA carry already implies the sum is at most 8'hFE, so OR is exact.
  assign carry_next_s = ksa_cout | (carry_q & (ksa_sum == 8'hFF));

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign ksa_a     = ksa_a_q;
  assign ksa_b     = ksa_b_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carryout_d  = carryout_q;
    overflow_d  = overflow_q;
    ksa_a_d     = 8'd0;
    ksa_b_d     = 8'd0;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub;
          idx_d   = '0;
          ksa_a_d = op_a[7:0];
          ksa_b_d = op_sub ? ~op_b[7:0] : op_b[7:0];
        end else begin
          idx_d = idx_q;
        end
      end
      RUN: begin
        acc_d[{idx_q, 3'b000} +: 8] = byte_s;
        carry_d = carry_next_s;
        if (last_s) begin
          idx_d      = '0;
          result_d   = {byte_s, acc_q[W-9:0]};
          carryout_d = carry_next_s;
          overflow_d = (a_q[W-1] == b_q[W-1]) & (byte_s[7] != a_q[W-1]);
        end else begin
          idx_d   = idx_inc_s;
          ksa_a_d = a_q[{idx_inc_s, 3'b000} +: 8];
          ksa_b_d = b_q[{idx_inc_s, 3'b000} +: 8];
        end
      end
      DONE: begin
        idx_d = idx_q;
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      ksa_a_q     <= 8'd0;
      ksa_b_q     <= 8'd0;
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      carryout_q  <= carryout_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      ksa_a_q     <= ksa_a_d;
      ksa_b_q     <= ksa_b_d;
    end
  end

endmodule

// File: tb/tb_ksa_multiword_seq.sv
// Directed bench for ksa_multiword_seq with a behavioural 8-bit KSA attached.
module tb_ksa_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_sub;
  logic [7:0]    ksa_a;
  logic [7:0]    ksa_b;
  logic [7:0]    ksa_sum;
  logic          ksa_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carryout;
  logic          overflow;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            lat;
  int            cnt;
  logic [W-1:0]  aseq;
  logic [W-1:0]  bseq;

  always #5 clk = ~clk;

  assign {ksa_cout, ksa_sum} = {1'b0, ksa_a} + {1'b0, ksa_b};

  ksa_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .ksa_a     (ksa_a),
    .ksa_b     (ksa_b),
    .ksa_sum   (ksa_sum),
    .ksa_cout  (ksa_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge, then scramble operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    op_sub   = ~sub;
  endtask

  // Wait (bounded) for out_valid, recording the byte slices shown to the KSA.
  task automatic wait_done();
    lat  = 0;
    aseq = '0;
    bseq = '0;
    while (!out_valid && lat < 20) begin
      aseq = {aseq[W-9:0], ksa_a};
      bseq = {bseq[W-9:0], ksa_b};
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_ov);
    issue(a, b, sub);
    wait_done();
    check({name, " latency"}, W'(lat), W'(WORDS));
    check({name, " result"}, result, exp_r);
    check({name, " carryout"}, W'(carryout), W'(exp_c));
    check({name, " overflow"}, W'(overflow), W'(exp_ov));
    check({name, " in_ready busy"}, W'(in_ready), W'(0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid drop"}, W'(out_valid), W'(0));
    check({name, " idle ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst in_ready", W'(in_ready), W'(1));
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst result", result, W'(0));
    check("rst carryout", W'(carryout), W'(0));
    check("rst overflow", W'(overflow), W'(0));
    check("rst ksa_a", W'(ksa_a), W'(0));
    check("rst ksa_b", W'(ksa_b), W'(0));
    @(negedge clk);

    op_check("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    check("add_ff_1 ksa_a seq", aseq, 32'hFF00_0000);
    check("add_ff_1 ksa_b seq", bseq, 32'h0100_0000);
    check("idle ksa_a", W'(ksa_a), W'(0));

    op_check("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    op_check("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("sub_5_7 ksa_b seq", bseq, 32'hF8FF_FFFF);
    op_check("sub_min_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op_check("add_max_1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Back-pressure: hold DONE while poking the request side.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done();
    check("bp latency", W'(lat), W'(WORDS));
    check("bp result", result, 32'h2345_6789);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      op_a     = $urandom;
      op_b     = $urandom;
      op_sub   = (k % 2 == 1);
      @(negedge clk);
      check("bp hold result", result, 32'h2345_6789);
      check("bp hold valid", W'(out_valid), W'(1));
      check("bp hold in_ready", W'(in_ready), W'(0));
      check("bp hold ksa_a", W'(ksa_a), W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release valid", W'(out_valid), W'(0));
    check("bp release in_ready", W'(in_ready), W'(1));
    check("bp release result", result, 32'h2345_6789);
    @(negedge clk);
    check("bp no accept", W'(in_ready), W'(1));

    // Throughput with out_ready tied high and a request always pending.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = 32'h0000_0001;
    op_b      = 32'h0000_0002;
    op_sub    = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("tput first valid", W'(out_valid), W'(1));
    check("tput first result", result, 32'h0000_0003);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 30);
    check("tput period", W'(cnt), W'(WORDS + 2));
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("tput idle valid", W'(out_valid), W'(0));

    // Abort mid-operation with reset at byte index 2.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort ksa_a idx2", W'(ksa_a), W'(8'hFF));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort result", result, W'(0));
    check("abort out_valid", W'(out_valid), W'(0));
    check("abort in_ready", W'(in_ready), W'(1));
    check("abort ksa_a", W'(ksa_a), W'(0));
    check("abort carryout", W'(carryout), W'(0));
    repeat (5) @(negedge clk);
    check("abort no valid", W'(out_valid), W'(0));
    op_check("post_abort", 32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
